// File: rtl/idex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: zero-register number, ALU op encoding,
// the control bundle carried into EX, and the register-match helper used for bypass and hazards.
package idex_stage_pkg;

   localparam logic [4:0] XZR = 5'd31;

   typedef enum logic [3:0] {
      ALU_AND   = 4'b0000,
      ALU_ORR   = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_SUB   = 4'b0110,
      ALU_PASSB = 4'b0111,
      ALU_NOR   = 4'b1100
   } alu_op_e;

   typedef struct packed {
      logic    regwrite;
      logic    memread;
      logic    memwrite;
      logic    memtoreg;
      logic    alusrc;
      alu_op_e alucontrol;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'(9'd0);

   // XZR is hard-wired zero, so a write to it never produces a usable value.
   function automatic logic reg_match(input logic we, input logic [4:0] wa, input logic [4:0] ra);
      return we && (wa == ra) && (ra != XZR);
   endfunction

endpackage

// File: rtl/idex_stage_fwd_mux.sv
// EX operand forwarding: the youngest producer (EX/MEM) wins over MEM/WB, else the captured value.
module fwd_mux
   import idex_stage_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [4:0]   ra,
   input  logic [W-1:0] stored,
   input  logic         exmem_regwrite,
   input  logic [4:0]   exmem_wa,
   input  logic [W-1:0] exmem_res,
   input  logic         memwb_regwrite,
   input  logic [4:0]   memwb_wa,
   input  logic [W-1:0] memwb_wd,
   output logic [W-1:0] op
);

   // Priority select between the two downstream producers and the stored operand.
   always_comb begin
      op = stored;
      if (reg_match(exmem_regwrite, exmem_wa, ra)) begin
         op = exmem_res;
      end else if (reg_match(memwb_regwrite, memwb_wa, ra)) begin
         op = memwb_wd;
      end else begin
         op = stored;
      end
   end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with write-back bypass at capture, load-use stall detection,
// EX operand forwarding and a saturating stall counter.
module idex_stage
   import idex_stage_pkg::*;
#(
   parameter int W  = 64,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid_id,
   input  logic [4:0]    ra1_id,
   input  logic [4:0]    ra2_id,
   input  logic [4:0]    wa_id,
   input  logic [W-1:0]  rd1_id,
   input  logic [W-1:0]  rd2_id,
   input  logic [W-1:0]  imm_id,
   input  logic          regwrite_id,
   input  logic          memread_id,
   input  logic          memwrite_id,
   input  logic          memtoreg_id,
   input  logic          alusrc_id,
   input  logic          usesb_id,
   input  logic [3:0]    alucontrol_id,
   input  logic          flush,
   input  logic          exmem_regwrite,
   input  logic          memwb_regwrite,
   input  logic [4:0]    exmem_wa,
   input  logic [4:0]    memwb_wa,
   input  logic [W-1:0]  exmem_res,
   input  logic [W-1:0]  memwb_wd,
   output logic          stall,
   output logic          valid_ex,
   output logic          regwrite_ex,
   output logic          memread_ex,
   output logic          memwrite_ex,
   output logic          memtoreg_ex,
   output logic          alusrc_ex,
   output logic [3:0]    alucontrol_ex,
   output logic [4:0]    wa_ex,
   output logic [W-1:0]  imm_ex,
   output logic [W-1:0]  opa_ex,
   output logic [W-1:0]  opb_ex,
   output logic [CW-1:0] stall_cnt
);

   logic          valid_ex_r;
   ctrl_t         ctrl_ex_r;
   logic [4:0]    ra1_ex_r;
   logic [4:0]    ra2_ex_r;
   logic [4:0]    wa_ex_r;
   logic [W-1:0]  a_ex_r;
   logic [W-1:0]  b_ex_r;
   logic [W-1:0]  imm_ex_r;
   logic [CW-1:0] stall_cnt_r;

   ctrl_t         ctrl_id_s;
   logic [W-1:0]  a_id_s;
   logic [W-1:0]  b_id_s;
   logic          stall_s;
   logic          bubble_s;

   // Load-use hazard against the load now in EX; a flush kills the dependent anyway.
   always_comb begin
      stall_s = 1'b0;
      if (valid_id && valid_ex_r && ctrl_ex_r.memread && !flush &&
          (reg_match(1'b1, wa_ex_r, ra1_id) || (usesb_id && reg_match(1'b1, wa_ex_r, ra2_id)))) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end
      bubble_s = flush | stall_s;
   end

   // Capture-side values: side-effect controls gated by valid, WB bypass, XZR reads as zero.
   always_comb begin
      ctrl_id_s.regwrite   = regwrite_id & valid_id;
      ctrl_id_s.memread    = memread_id & valid_id;
      ctrl_id_s.memwrite   = memwrite_id & valid_id;
      ctrl_id_s.memtoreg   = memtoreg_id;
      ctrl_id_s.alusrc     = alusrc_id;
      ctrl_id_s.alucontrol = alu_op_e'(alucontrol_id);
      a_id_s = rd1_id;
      b_id_s = rd2_id;
      if (ra1_id == XZR) begin
         a_id_s = '0;
      end else if (reg_match(memwb_regwrite, memwb_wa, ra1_id)) begin
         a_id_s = memwb_wd;
      end else begin
         a_id_s = rd1_id;
      end
      if (ra2_id == XZR) begin
         b_id_s = '0;
      end else if (reg_match(memwb_regwrite, memwb_wa, ra2_id)) begin
         b_id_s = memwb_wd;
      end else begin
         b_id_s = rd2_id;
      end
   end

   // ID/EX pipeline register; a bubble points both sources at XZR so nothing forwards into it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_ex_r <= 1'b0;
         ctrl_ex_r  <= CTRL_NOP;
         ra1_ex_r   <= XZR;
         ra2_ex_r   <= XZR;
         wa_ex_r    <= XZR;
         a_ex_r     <= '0;
         b_ex_r     <= '0;
         imm_ex_r   <= '0;
      end else if (bubble_s) begin
         valid_ex_r <= 1'b0;
         ctrl_ex_r  <= CTRL_NOP;
         ra1_ex_r   <= XZR;
         ra2_ex_r   <= XZR;
         wa_ex_r    <= XZR;
         a_ex_r     <= '0;
         b_ex_r     <= '0;
         imm_ex_r   <= '0;
      end else begin
         valid_ex_r <= valid_id;
         ctrl_ex_r  <= ctrl_id_s;
         ra1_ex_r   <= ra1_id;
         ra2_ex_r   <= ra2_id;
         wa_ex_r    <= wa_id;
         a_ex_r     <= a_id_s;
         b_ex_r     <= b_id_s;
         imm_ex_r   <= imm_id;
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= '0;
      end else if (stall_s && (stall_cnt_r != {CW{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   fwd_mux #(.W(W)) u_fwd_a (
      .ra             (ra1_ex_r),
      .stored         (a_ex_r),
      .exmem_regwrite (exmem_regwrite),
      .exmem_wa       (exmem_wa),
      .exmem_res      (exmem_res),
      .memwb_regwrite (memwb_regwrite),
      .memwb_wa       (memwb_wa),
      .memwb_wd       (memwb_wd),
      .op             (opa_ex)
   );

   fwd_mux #(.W(W)) u_fwd_b (
      .ra             (ra2_ex_r),
      .stored         (b_ex_r),
      .exmem_regwrite (exmem_regwrite),
      .exmem_wa       (exmem_wa),
      .exmem_res      (exmem_res),
      .memwb_regwrite (memwb_regwrite),
      .memwb_wa       (memwb_wa),
      .memwb_wd       (memwb_wd),
      .op             (opb_ex)
   );

   assign stall         = stall_s;
   assign valid_ex      = valid_ex_r;
   assign regwrite_ex   = ctrl_ex_r.regwrite;
   assign memread_ex    = ctrl_ex_r.memread;
   assign memwrite_ex   = ctrl_ex_r.memwrite;
   assign memtoreg_ex   = ctrl_ex_r.memtoreg;
   assign alusrc_ex     = ctrl_ex_r.alusrc;
   assign alucontrol_ex = ctrl_ex_r.alucontrol;
   assign wa_ex         = wa_ex_r;
   assign imm_ex        = imm_ex_r;
   assign stall_cnt     = stall_cnt_r;

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 Parameter W, default 64: datapath width of operands, immediate and forwarded results.
REQ-002 Parameter CW, default 32: width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it low clears all state immediately.
REQ-005 valid_id  input  1  decode stage holds a real instruction.
REQ-006 ra1_id, ra2_id, wa_id  input  5 each  source and destination register numbers from decode.
REQ-007 rd1_id, rd2_id  input  W each  register-file read data for ra1_id/ra2_id.
REQ-008 imm_id  input  W  sign-extended immediate.
REQ-009 regwrite_id, memread_id, memwrite_id, memtoreg_id, alusrc_id, usesb_id  input  1 each  decode control bits; usesb_id is high when ra2 is a real source.
REQ-010 alucontrol_id  input  4  ALU operation.
REQ-011 flush  input  1  branch taken; kill the instruction entering EX.
REQ-012 exmem_regwrite, memwb_regwrite  input  1 each  downstream write enables.
REQ-013 exmem_wa, memwb_wa  input  5 each  downstream destination registers.
REQ-014 exmem_res, memwb_wd  input  W each  EX/MEM ALU result; MEM/WB write-back data.
REQ-015 stall  output  1  load-use hazard; PC and IF/ID hold this cycle.
REQ-016 valid_ex, regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex  output  1 each  registered controls.
REQ-017 alucontrol_ex  output  4; wa_ex  output  5; imm_ex  output  W  registered fields.
REQ-018 opa_ex, opb_ex  output  W each  forwarded EX operands (opb_ex before ALUSrc mux).
REQ-019 stall_cnt  output  CW  count of stall cycles.

Function
REQ-020 Register 31 (XZR) SHALL never match: no forwarding, bypass or hazard on address 31; operands for ra=31 are 0.
REQ-021 WB bypass at capture: if memwb_regwrite and memwb_wa==ra1_id, register A captures memwb_wd, else rd1_id; same for B/ra2_id.
REQ-022 stall = valid_id & valid_ex & memread_ex & wa_ex!=31 & (ra1_id==wa_ex | (usesb_id & ra2_id==wa_ex)) & !flush; combinational.
REQ-023 Each posedge: flush or stall -> capture bubble (valid_ex=0, all controls 0, wa_ex=31, data 0); else capture all _id fields, valid_ex=valid_id.
REQ-024 A bubble or valid_id=0 capture SHALL force regwrite/memread/memwrite low.
REQ-025 opa_ex: if exmem_regwrite & exmem_wa==ra1_ex -> exmem_res; else if memwb_regwrite & memwb_wa==ra1_ex -> memwb_wd; else stored A. opb_ex identical on ra2_ex/B.
REQ-026 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-027 stall_cnt increments by 1 each cycle stall=1, saturating at all-ones.
REQ-028 Latency: captured fields visible on _ex outputs the cycle after the edge; opa/opb combinational from _ex state and forwarding inputs.

Reset
REQ-029 reset low SHALL asynchronously set valid_ex=0, all controls 0, wa_ex=31, ra1_ex=ra2_ex=31, data/imm 0, stall_cnt=0.
REQ-030 Reset deassertion mid-stream: first capture occurs at the first posedge with reset high; stall is 0 while valid_ex=0.

Structure
REQ-031 Shared package SHALL hold XZR=5'd31, the ALU-control encoding typedef and a packed ctrl_t struct for the control bundle.
REQ-032 One sub-module fwd_mux (one instance per operand) SHALL implement REQ-025/026; the rest lives in idex_stage.

Verification
REQ-033 ID: ADD ra1=2, rd1=2; EX/MEM writes X2=0x55 -> next cycle opa_ex=0x55.
REQ-034 EX/MEM and MEM/WB both write X5 (0xAA, 0xBB), ra2_ex=5 -> opb_ex=0xAA.
REQ-035 LDUR X9 in EX, ADD ra1=9 in ID -> stall=1 one cycle, bubble (valid_ex=0), stall_cnt 0->1, ADD enters EX next cycle.
REQ-036 memwb writes X31=0x77, ra1_id=31 -> opa_ex=0, no stall on LDUR to X31.
REQ-037 flush high together with load-use condition -> stall=0, bubble captured, stall_cnt unchanged.
REQ-038 reset low mid-cycle with valid_ex=1 -> outputs clear immediately without clock edge.
